// File: rtl/fpnew_opgroup_out_arb_pkg.sv
// Helpers local to the op-group output arbiter.
package fpnew_opgroup_out_arb_pkg;

  // Width of a round-robin index; a single input still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = (n > 32'd1) ? $clog2(n) : 32'd1;
    return w;
  endfunction

endpackage

// File: rtl/fpnew_pkg.sv
// Shared FPU package: IEEE 754 exception flag bundle used by every op group.
package fpnew_pkg;

  typedef struct packed {
    logic NV; // invalid
    logic DZ; // divide by zero
    logic OF; // overflow
    logic UF; // underflow
    logic NX; // inexact
  } status_t;

endpackage

// File: rtl/fpnew_skid_reg.sv
// Two-entry output register (main + skid). Main drives the outputs; skid
// absorbs one transfer accepted while main is stalled, so upstream ready
// is a pure register output with no path from out_ready_i.
module fpnew_skid_reg #(
  parameter type DataType = logic
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    flush_i,
  input  logic    in_valid_i,
  input  DataType in_data_i,
  output logic    in_ready_o,
  output logic    out_valid_o,
  input  logic    out_ready_i,
  output DataType out_data_o,
  output logic    skid_valid_o
);

  logic    main_valid;
  logic    skid_valid;
  DataType main_data;
  DataType skid_data;
  logic    drain;

  // Main register may take new data when empty or being consumed.
  always_comb begin
    drain = ~main_valid | out_ready_i;
  end

  // Main/skid state: reset beats flush, flush beats any transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush_i) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (drain) begin
      if (skid_valid) begin
        // Upstream ready is low while skid is full, so no input collides here.
        main_data  <= skid_data;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_valid_i) begin
        main_data  <= in_data_i;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_valid_i) begin
      skid_data  <= in_data_i;
      skid_valid <= 1'b1;
    end else begin
      main_valid <= main_valid;
    end
  end

  assign in_ready_o   = ~skid_valid;
  assign out_valid_o  = main_valid;
  assign out_data_o   = main_data;
  assign skid_valid_o = skid_valid;

endmodule

// File: rtl/fpnew_opgroup_out_arb.sv
// Round-robin arbiter collecting results from the format slices of one
// operation group onto a single registered output channel.
module fpnew_opgroup_out_arb
  import fpnew_pkg::*;
  import fpnew_opgroup_out_arb_pkg::*;
#(
  parameter int unsigned NumInputs = 4,
  parameter int unsigned Width     = 64,
  parameter type         TagType   = logic
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic [NumInputs-1:0][Width-1:0]  slice_result_i,
  input  status_t [NumInputs-1:0]          slice_status_i,
  input  logic [NumInputs-1:0]             slice_ext_bit_i,
  input  TagType [NumInputs-1:0]           slice_tag_i,
  input  logic [NumInputs-1:0]             slice_valid_i,
  output logic [NumInputs-1:0]             slice_ready_o,
  input  logic [NumInputs-1:0]             slice_busy_i,
  output logic [Width-1:0]                 result_o,
  output status_t                          status_o,
  output logic                             extension_bit_o,
  output TagType                           tag_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic                             busy_o
);

  localparam int unsigned IDX_W = idx_width(NumInputs);

  typedef struct packed {
    logic [Width-1:0] result;
    status_t          status;
    logic             ext_bit;
    TagType           tag;
  } slice_data_t;

  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     grant_idx;
  logic [NumInputs-1:0] grant;
  logic                 found;
  logic                 accept;
  logic                 skid_ready;
  logic                 skid_valid;
  slice_data_t          sel_data;
  slice_data_t          main_data;

  // Pick the first valid slice at or after rr_ptr, wrapping around.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int unsigned off = 0; off < NumInputs; off++) begin
      if (!found && slice_valid_i[(32'(rr_ptr) + off) % NumInputs]) begin
        found     = 1'b1;
        grant_idx = IDX_W'((32'(rr_ptr) + off) % NumInputs);
        grant[(32'(rr_ptr) + off) % NumInputs] = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  // Ready only from registered skid state and flush, never from out_ready_i.
  always_comb begin
    slice_ready_o = grant & {NumInputs{skid_ready & ~flush_i}};
    accept        = |(slice_valid_i & slice_ready_o);
    sel_data.result  = slice_result_i[grant_idx];
    sel_data.status  = slice_status_i[grant_idx];
    sel_data.ext_bit = slice_ext_bit_i[grant_idx];
    sel_data.tag     = slice_tag_i[grant_idx];
  end

  // Advance the round-robin pointer past the slice just accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= IDX_W'((32'(grant_idx) + 32'd1) % NumInputs);
    end else begin
      rr_ptr <= rr_ptr;
    end
  end

  fpnew_skid_reg #(
    .DataType (slice_data_t)
  ) u_skid (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .in_valid_i   (accept),
    .in_data_i    (sel_data),
    .in_ready_o   (skid_ready),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (main_data),
    .skid_valid_o (skid_valid)
  );

  assign result_o        = main_data.result;
  assign status_o        = main_data.status;
  assign extension_bit_o = main_data.ext_bit;
  assign tag_o           = main_data.tag;
  assign busy_o          = out_valid_o | skid_valid | (|slice_busy_i);

endmodule

// File: doc/fpnew_opgroup_out_arb.md
Name: fpnew_opgroup_out_arb

Overview:
- Collects results from NumInputs format slices of one operation group and arbitrates them round-robin onto a single output channel.
- Sits directly downstream of the per-format slices; feeds the FPU top-level output mux.
- Output is fully registered through a 2-entry skid buffer: 1-cycle latency, 1 result/cycle throughput, no combinational path from out_ready_i to in_ready_o.

Parameters:
- NumInputs, 4, number of slices arbitrated (>=1).
- Width, 64, result width in bits.
- TagType, logic, tag type carried alongside each result.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  synchronous flush; drops all buffered results.
- slice_result_i  in  [NumInputs][Width]  per-slice result.
- slice_status_i  in  [NumInputs] fpnew_pkg::status_t  per-slice exception flags.
- slice_ext_bit_i  in  [NumInputs]  per-slice extension bit.
- slice_tag_i  in  [NumInputs] TagType  per-slice tag.
- slice_valid_i  in  [NumInputs]  per-slice output valid.
- slice_ready_o  out  [NumInputs]  per-slice ready, one-hot or zero.
- slice_busy_i  in  [NumInputs]  per-slice busy.
- result_o  out  Width  selected result.
- status_o  out  fpnew_pkg::status_t  selected flags.
- extension_bit_o  out  1  selected extension bit.
- tag_o  out  TagType  selected tag.
- out_valid_o  out  1  output valid.
- out_ready_i  in  1  downstream ready.
- busy_o  out  1  data in flight anywhere in the group.

Behaviour:
- Reset (rst_i=1 at a clock edge): out_valid_o=0; skid_valid=0; rr_ptr=0; result_o, status_o, extension_bit_o, tag_o all 0. Reset wins over flush and over any transfer in the same cycle.
- Arbitration (combinational):
  - Grant the lowest index i with slice_valid_i[i]=1, searching from rr_ptr upward and wrapping modulo NumInputs.
  - No valid input means no grant.
- Ready:
  - slice_ready_o[i] = grant[i] & ~skid_valid & ~flush_i.
  - skid_valid is a register, so ready never depends on out_ready_i.
  - An accept is slice_valid_i[i] & slice_ready_o[i].
- Pointer update: on an accept from index g, rr_ptr <= (g+1) mod NumInputs. Otherwise rr_ptr holds, including during flush.
- Output stage ("main" register drives the outputs, "skid" register holds overflow):
  - drain = ~out_valid_o | out_ready_i.
  - If drain and skid_valid: main <= skid; skid_valid <= 0. A same-cycle accept is impossible, because ready is low.
  - Else if drain and accept: main <= granted slice fields; out_valid_o <= 1.
  - Else if drain and no accept: out_valid_o <= 0.
  - If ~drain and accept: skid <= granted slice fields; skid_valid <= 1.
- Latency: an accept in cycle N gives out_valid_o=1 in cycle N+1 when the main register drains.
- Hold rule: while out_valid_o & ~out_ready_i, all outputs hold stable.
- Flush: in the next cycle out_valid_o=0 and skid_valid=0. No accept occurs in the flush cycle. Data registers may keep stale values.
- busy_o = out_valid_o | skid_valid | (|slice_busy_i).
- Fields pass through unmodified; no arithmetic, no width conversion.
- Ordering: results from a single slice leave in acceptance order. Across slices, order follows grant order.
- NumInputs=1: arbiter degenerates to pass-through; rr_ptr is constant 0.

Decomposition:
- fpnew_pkg provides status_t (existing).
- Local constant: IDX_W = max(1, $clog2(NumInputs)), the width of rr_ptr.
- Sub-module fpnew_skid_reg (parameter type DataType, 2-entry main+skid, valid/ready, synchronous active-high reset and flush). Data is a packed struct {result, status, ext_bit, tag}.
- The arbiter stays in the top module.

Test Plan:
- Reset, then hold all slice_valid_i=0 -> out_valid_o=0, slice_ready_o=0, busy_o=0, result_o=0.
- slice 2 valid, result=64'h4000_0000_0000_0000, tag=1, out_ready_i=1 -> slice_ready_o=4'b0100 in the same cycle; next cycle out_valid_o=1 with the same result/tag; rr_ptr=3.
- All 4 slices valid continuously, out_ready_i=1, rr_ptr=0 -> grants 0,1,2,3,0 on consecutive cycles; one output per cycle.
- Slices 0 and 1 each accepted once, out_ready_i=0 after the first accept -> second result lands in skid; slice_ready_o=0 until drained; out_ready_i=1 then yields slice 0 then slice 1 on consecutive cycles.
- Outputs full and skid full, pulse flush_i -> next cycle out_valid_o=0, busy_o=slice busy only, rr_ptr unchanged, no accept in the flush cycle.
- Assert rst_i mid-stream with skid full and out_ready_i=0 -> next cycle all outputs 0, rr_ptr=0; the first accept after deassert is granted from index 0.
